// File: rtl/corefifo_resetgen_vdma.sv
// rtl/corefifo_resetgen_vdma.sv - VDMA reset sequencer: min-width assert, ordered release, ack wait
// Optional feature macro: VDMA_RST_TIMEOUT_EN (sticky WAIT_ACK timeout flag).
module corefifo_resetgen_vdma #(
    parameter int NUM_DOMAINS       = 3,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int RELEASE_GAP       = 4,
    parameter int ACK_SYNC_STAGES   = 2,
    parameter int ACK_TIMEOUT       = 1024,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_rst_req,
    input  logic                   rst_ack_n,
    output logic [NUM_DOMAINS-1:0] rst_out_n,
    output logic                   rst_busy,
    output logic                   rst_done,
    output logic                   rst_timeout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ASSERT   = 3'd1;
    localparam logic [2:0] ST_RELEASE  = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_WIDTH-1:0] ASSERT_LAST = CNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST    = CNT_WIDTH'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0]     IDX_FIRST   = IDX_W'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 1 || MIN_ASSERT_CYCLES < 1 || RELEASE_GAP < 1 ||
        ACK_SYNC_STAGES < 2 || ACK_TIMEOUT < 1 ||
        longint'(MIN_ASSERT_CYCLES) > (longint'(1) << CNT_WIDTH) ||
        longint'(RELEASE_GAP) > (longint'(1) << CNT_WIDTH) ||
        longint'(ACK_TIMEOUT) > (longint'(1) << CNT_WIDTH)) begin : g_bad_cfg
        $error("corefifo_resetgen_vdma: invalid parameter set");
    end

    logic [2:0]                 state;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [IDX_W-1:0]           idx;
    logic [ACK_SYNC_STAGES-1:0] ack_sync;
    logic                       ack_ok;

    assign ack_ok = ack_sync[ACK_SYNC_STAGES-1];

    // Synchronizer is flushed outside WAIT_ACK so a stale high ack from an
    // earlier sequence can never complete the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync <= '0;
        end else if (state != ST_WAIT_ACK) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], rst_ack_n};
        end
    end

`ifdef VDMA_RST_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(ACK_TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_timeout <= 1'b0;
        end else if (soft_rst_req) begin
            rst_timeout <= 1'b0;
        end else if (state == ST_WAIT_ACK && !ack_ok && cnt == TIMEOUT_LAST) begin
            rst_timeout <= 1'b1;
        end
    end
`else
    assign rst_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            idx       <= '0;
            rst_out_n <= '0;
            rst_busy  <= 1'b1;
            rst_done  <= 1'b0;
        end else begin
            rst_done <= 1'b0;
            // A request from any state (re)starts the full low window.
            if (soft_rst_req) begin
                state     <= ST_ASSERT;
                cnt       <= '0;
                idx       <= '0;
                rst_out_n <= '0;
                rst_busy  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        rst_busy <= 1'b0;
                    end
                    ST_ASSERT: begin
                        if (cnt == ASSERT_LAST) begin
                            cnt          <= '0;
                            rst_out_n[0] <= 1'b1;
                            if (NUM_DOMAINS == 1) begin
                                state <= ST_WAIT_ACK;
                            end else begin
                                idx   <= IDX_FIRST;
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            cnt            <= '0;
                            rst_out_n[idx] <= 1'b1;
                            if (idx == IDX_LAST) begin
                                state <= ST_WAIT_ACK;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (ack_ok) begin
                            state    <= ST_DONE;
                            rst_done <= 1'b1;
                            rst_busy <= 1'b0;
                        end
`ifdef VDMA_RST_TIMEOUT_EN
                        else if (cnt == TIMEOUT_LAST) begin
                            state    <= ST_DONE;
                            rst_done <= 1'b1;
                            rst_busy <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state     <= ST_ASSERT;
                        cnt       <= '0;
                        idx       <= '0;
                        rst_out_n <= '0;
                        rst_busy  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corefifo_resetgen_vdma.sv
// tb/tb_corefifo_resetgen_vdma.sv - scoreboard bench for corefifo_resetgen_vdma
module tb_corefifo_resetgen_vdma;

    localparam int ND   = 3;
    localparam int MIN  = 16;
    localparam int GAP  = 4;
    localparam int SYNC = 2;
    localparam int TMO  = 1024;
    localparam int CW   = 16;

    typedef struct {
        int            cyc;
        logic [ND+1:0] snap;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic          rst_ack_n = 1'b1;
    logic [ND-1:0] rst_out_n;
    logic          rst_busy;
    logic          rst_done;
    logic          rst_timeout;
    logic [ND+1:0] snap;
    logic [ND+1:0] mon_prev = '0;
    bit            mon_en = 1'b0;

    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    corefifo_resetgen_vdma #(
        .NUM_DOMAINS(ND), .MIN_ASSERT_CYCLES(MIN), .RELEASE_GAP(GAP),
        .ACK_SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req), .rst_ack_n(rst_ack_n),
        .rst_out_n(rst_out_n), .rst_busy(rst_busy), .rst_done(rst_done),
        .rst_timeout(rst_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign snap = {rst_out_n, rst_busy, rst_done};

    // Records every output change with the number of the edge that caused it.
    always @(negedge clk) begin
        if (mon_en && snap !== mon_prev) obs_q.push_back('{cyc, snap});
        mon_prev <= snap;
    end

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_ev(input int c, input logic [ND-1:0] o, input logic b, input logic d);
        ev_t e;
        e.cyc  = c;
        e.snap = {o, b, d};
        exp_q.push_back(e);
    endtask

    // Expected output changes of a sequence whose ASSERT window starts at edge s.
    task automatic push_seq(input int s, input bit with_start, input int tail);
        int w;
        w = s + MIN + (ND - 1) * GAP;
        if (with_start) push_ev(s, '0, 1'b1, 1'b0);
        for (int i = 0; i < ND; i++) push_ev(s + MIN + i * GAP, ND'((1 << (i + 1)) - 1), 1'b1, 1'b0);
        if (tail >= 1) push_ev(w + SYNC + 1, '1, 1'b0, 1'b1);
        if (tail >= 2) push_ev(w + SYNC + 2, '1, 1'b0, 1'b0);
    endtask

    task automatic request_at(input int e);
        to_cyc(e - 1);
        soft_rst_req = 1'b1;
        to_cyc(e);
        soft_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rst_ack_n = 1'b1;
        soft_rst_req = 1'b0;
        to_cyc(3);
        vectors++;
        if (rst_out_n !== '0) begin miscompares++; $display("FAIL reset_out_n: got %b expected %b", rst_out_n, 3'b000); end
        vectors++;
        if (rst_busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b expected 1", rst_busy); end
        vectors++;
        if (rst_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", rst_done); end
        vectors++;
        if (rst_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b expected 0", rst_timeout); end
    endtask

    task automatic test_power_on();
        int  r;
        ev_t ex, ob;
        r = cyc;
        #1;
        exp_q.delete(); obs_q.delete();
        mon_en = 1'b1;
        push_seq(r, 1'b0, 2);
        reset = 1'b1;
        to_cyc(r + 40);
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL power_on: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL power_on: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL power_on_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    task automatic test_soft_idle();
        int  e;
        ev_t ex, ob;
        exp_q.delete(); obs_q.delete();
        e = cyc + 2;
        push_seq(e, 1'b1, 2);
        request_at(e);
        to_cyc(e + 40);
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL soft_idle: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL soft_idle: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL soft_idle_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    task automatic test_mid_release_abort();
        int  e;
        ev_t ex, ob;
        exp_q.delete(); obs_q.delete();
        e = cyc + 2;
        push_ev(e, '0, 1'b1, 1'b0);
        push_ev(e + MIN, 3'b001, 1'b1, 1'b0);
        push_seq(e + MIN + 2, 1'b1, 2);
        request_at(e);
        request_at(e + MIN + 2);
        to_cyc(e + MIN + 2 + 40);
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL abort: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL abort: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL abort_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    task automatic test_assert_extend();
        int  e;
        ev_t ex, ob;
        exp_q.delete(); obs_q.delete();
        e = cyc + 2;
        push_ev(e, '0, 1'b1, 1'b0);
        push_seq(e + 10, 1'b0, 2);
        request_at(e);
        request_at(e + 10);
        to_cyc(e + 10 + 40);
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL assert_extend: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL assert_extend: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL assert_extend_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    task automatic test_back_to_back();
        int  e, d;
        ev_t ex, ob;
        exp_q.delete(); obs_q.delete();
        e = cyc + 2;
        push_ev(e, '0, 1'b1, 1'b0);
        push_seq(e + 2, 1'b0, 1);
        d = e + 2 + MIN + (ND - 1) * GAP + SYNC + 1;
        push_ev(d + 1, '0, 1'b1, 1'b0);
        push_seq(d + 1, 1'b0, 2);
        to_cyc(e - 1);
        soft_rst_req = 1'b1;
        to_cyc(e + 2);
        soft_rst_req = 1'b0;
        request_at(d + 1);
        to_cyc(d + 1 + 40);
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL back_to_back: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL back_to_back: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL back_to_back_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    task automatic test_ack_low();
        int  e, w;
        ev_t ex, ob;
        exp_q.delete(); obs_q.delete();
        rst_ack_n = 1'b0;
        e = cyc + 2;
        w = e + MIN + (ND - 1) * GAP;
        push_seq(e, 1'b1, 0);
`ifdef VDMA_RST_TIMEOUT_EN
        push_ev(w + TMO, '1, 1'b0, 1'b1);
        push_ev(w + TMO + 1, '1, 1'b0, 1'b0);
        request_at(e);
        to_cyc(w + TMO - 1);
        vectors++;
        if (rst_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b expected 0", rst_timeout); end
        to_cyc(w + TMO);
        vectors++;
        if (rst_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_set: got %b expected 1", rst_timeout); end
        to_cyc(w + TMO + 6);
        vectors++;
        if (rst_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b expected 1", rst_timeout); end
`else
        request_at(e);
        to_cyc(w + 200);
        vectors++;
        if (rst_busy !== 1'b1 || rst_out_n !== '1) begin miscompares++; $display("FAIL ack_hold: got busy %b out %b expected busy 1 out 111", rst_busy, rst_out_n); end
        rst_ack_n = 1'b1;
        push_ev(w + 200 + SYNC + 1, '1, 1'b0, 1'b1);
        push_ev(w + 200 + SYNC + 2, '1, 1'b0, 1'b0);
        to_cyc(w + 210);
`endif
        rst_ack_n = 1'b1;
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL ack_low: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL ack_low: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL ack_low_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    task automatic test_async_reset();
        int  e, w, q;
        ev_t ex, ob;
        mon_en = 1'b0;
        rst_ack_n = 1'b0;
        e = cyc + 2;
        w = e + MIN + (ND - 1) * GAP;
        request_at(e);
`ifdef VDMA_RST_TIMEOUT_EN
        vectors++;
        if (rst_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_soft_clear: got %b expected 0", rst_timeout); end
`endif
        to_cyc(w + 5);
        vectors++;
        if (rst_out_n !== '1 || rst_busy !== 1'b1) begin miscompares++; $display("FAIL wait_ack_state: got out %b busy %b expected out 111 busy 1", rst_out_n, rst_busy); end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (rst_out_n !== '0 || rst_busy !== 1'b1 || rst_done !== 1'b0 || rst_timeout !== 1'b0)
        begin miscompares++; $display("FAIL async_reset: got out %b busy %b done %b tmo %b expected 000 1 0 0", rst_out_n, rst_busy, rst_done, rst_timeout); end
        rst_ack_n = 1'b1;
        q = cyc + 2;
        to_cyc(q);
        #1;
        exp_q.delete(); obs_q.delete();
        mon_en = 1'b1;
        push_seq(q, 1'b0, 2);
        reset = 1'b1;
        to_cyc(q + 40);
        #1;
        while (exp_q.size() > 0) begin
            ex = exp_q.pop_front(); vectors++;
            if (obs_q.size() == 0) begin miscompares++; $display("FAIL async_reset_seq: missing event, expected cyc %0d snap %b", ex.cyc, ex.snap); end
            else begin
                ob = obs_q.pop_front();
                if (ob.cyc !== ex.cyc || ob.snap !== ex.snap) begin miscompares++; $display("FAIL async_reset_seq: got cyc %0d snap %b expected cyc %0d snap %b", ob.cyc, ob.snap, ex.cyc, ex.snap); end
            end
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL async_reset_extra: got %0d extra events expected 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_idle();
        test_mid_release_abort();
        test_assert_extend();
        test_back_to_back();
        test_ack_low();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
